// File: rtl/xoodyak_vector_driver_pkg.sv
// Shared types and helpers for the XOODYAK vector driver.
// FSM encoding, byte width and the saturating counter step.
package xoodyak_tb_pkg;

    localparam int XOODYAK_BYTE_W   = 8;
    localparam int DEF_DIGEST_BYTES = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        START,
        COLLECT,
        CHECK
    } state_e;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] top;
        top = (32'd1 << w) - 32'd1;
        return (v == top) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/xoodyak_vector_driver_if.sv
// Config, byte-source and XOODYAK core signals of the vector driver.
// master = driver side, slave = environment side.
interface xoodyak_vector_driver_if
    import xoodyak_tb_pkg::*;
#(
    parameter int LEN_W        = 12,
    parameter int DIGEST_BYTES = DEF_DIGEST_BYTES
);
    logic                                   cfg_valid;
    logic                                   cfg_ready;
    logic [LEN_W-1:0]                       cfg_len;
    logic [XOODYAK_BYTE_W*DIGEST_BYTES-1:0] cfg_exp;
    logic                                   src_valid;
    logic                                   src_ready;
    logic [XOODYAK_BYTE_W-1:0]              src_data;
    logic                                   load;
    logic [XOODYAK_BYTE_W-1:0]              msg;
    logic [LEN_W-1:0]                       msg_len;
    logic                                   start;
    logic [XOODYAK_BYTE_W-1:0]              hash;
    logic                                   hash_valid;

    modport master (
        output cfg_ready, src_ready, load, msg, msg_len, start,
        input  cfg_valid, cfg_len, cfg_exp, src_valid, src_data,
        input  hash, hash_valid
    );

    modport slave (
        input  cfg_ready, src_ready, load, msg, msg_len, start,
        output cfg_valid, cfg_len, cfg_exp, src_valid, src_data,
        output hash, hash_valid
    );
endinterface

// File: rtl/xoodyak_vector_driver_collector.sv
// Digest shift register, byte counter and comparator.
// XVD_MISMATCH_DEBUG_EN adds the digest and first-mismatch index outputs.
module xvd_digest_collector
    import xoodyak_tb_pkg::*;
#(
    parameter int DIGEST_BYTES = DEF_DIGEST_BYTES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear,
    input  logic                                   en,
    input  logic                                   hash_valid,
    input  logic [XOODYAK_BYTE_W-1:0]              hash,
    input  logic [XOODYAK_BYTE_W*DIGEST_BYTES-1:0] exp_i,
    output logic                                   full,
    output logic                                   match
`ifdef XVD_MISMATCH_DEBUG_EN
    ,
    output logic [XOODYAK_BYTE_W*DIGEST_BYTES-1:0] digest,
    output logic [$clog2(DIGEST_BYTES):0]          mm_idx
`endif
);
    localparam int DW = XOODYAK_BYTE_W * DIGEST_BYTES;
    localparam int NW = $clog2(DIGEST_BYTES) + 1;

    logic [DW-1:0] dig_q, dig_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          take;

    assign take  = en & hash_valid;
    assign full  = take & (cnt_q == NW'(DIGEST_BYTES - 1));
    assign match = (dig_q == exp_i);

    always_comb begin
        dig_d = dig_q;
        cnt_d = cnt_q;
        if (clear) begin
            dig_d = '0;
            cnt_d = '0;
        end else if (take) begin
            dig_d = {dig_q[DW-XOODYAK_BYTE_W-1:0], hash};
            cnt_d = cnt_q + NW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_q <= '0;
            cnt_q <= '0;
        end else begin
            dig_q <= dig_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef XVD_MISMATCH_DEBUG_EN
    assign digest = dig_q;

    // Scan LSB-side first so the last hit is the byte nearest the MSB.
    always_comb begin
        mm_idx = NW'(DIGEST_BYTES);
        for (int k = DIGEST_BYTES - 1; k >= 0; k--) begin
            if (dig_q[8*(DIGEST_BYTES-1-k) +: 8] !=
                exp_i[8*(DIGEST_BYTES-1-k) +: 8])
                mm_idx = NW'(k);
        end
    end
`endif
endmodule

// File: rtl/xoodyak_vector_driver.sv
// Streams one test vector into XOODYAK, collects and checks the digest.
// Define XVD_MISMATCH_DEBUG_EN to expose obs_digest and mm_idx.
module xoodyak_vector_driver
    import xoodyak_tb_pkg::*;
#(
    parameter int DIGEST_BYTES   = DEF_DIGEST_BYTES,
    parameter int LEN_W          = 12,
    parameter int GAP_CYCLES     = 5,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    xoodyak_vector_driver_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [CNT_W-1:0]       tmo_cnt
`ifdef XVD_MISMATCH_DEBUG_EN
    ,
    output logic [8*DIGEST_BYTES-1:0]      obs_digest,
    output logic [$clog2(DIGEST_BYTES):0]  mm_idx
`endif
);
    localparam int DW  = XOODYAK_BYTE_W * DIGEST_BYTES;
    localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW  = $clog2(GAP_CYCLES) + 1;
    localparam int CW0 = (LEN_W > TW) ? LEN_W : TW;
    localparam int CW  = (CW0 > GW) ? CW0 : GW;

    state_e           state_q, state_d;
    logic [CW-1:0]    ctr_q, ctr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DW-1:0]    exp_q, exp_d;
    logic             pass_q, pass_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] pc_q, pc_d, fc_q, fc_d, tc_q, tc_d;
    logic             clr, col_en, full, match;

`ifdef XVD_MISMATCH_DEBUG_EN
    localparam int IW = $clog2(DIGEST_BYTES) + 1;
    logic [DW-1:0] digest, obs_q;
    logic [IW-1:0] mm_c, mm_q;
`endif

    xvd_digest_collector #(.DIGEST_BYTES(DIGEST_BYTES)) u_col (
        .clk        (clk),
        .rst        (reset),
        .clear      (clr),
        .en         (col_en),
        .hash_valid (bus.hash_valid),
        .hash       (bus.hash),
        .exp_i      (exp_q),
        .full       (full),
        .match      (match)
`ifdef XVD_MISMATCH_DEBUG_EN
        ,
        .digest     (digest),
        .mm_idx     (mm_c)
`endif
    );

    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        len_d         = len_q;
        exp_d         = exp_q;
        pass_d        = pass_q;
        tmo_d         = tmo_q;
        pc_d          = pc_q;
        fc_d          = fc_q;
        tc_d          = tc_q;
        clr           = 1'b0;
        col_en        = 1'b0;
        done          = 1'b0;
        bus.cfg_ready = 1'b0;
        bus.src_ready = 1'b0;
        bus.load      = 1'b0;
        bus.msg       = '0;
        bus.start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid) begin
                    len_d   = bus.cfg_len;
                    exp_d   = bus.cfg_exp;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                    clr     = 1'b1;
                    ctr_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.src_ready = 1'b1;
                bus.load      = bus.src_valid;
                bus.msg       = bus.src_data;
                if (bus.src_valid) begin
                    // msg_len+1 bytes: counter runs 0..len inclusive
                    if (ctr_q == CW'(len_q)) begin
                        ctr_d   = '0;
                        state_d = GAP;
                    end else begin
                        ctr_d = ctr_q + CW'(1);
                    end
                end
            end
            GAP: begin
                if (ctr_q == CW'(GAP_CYCLES - 1)) begin
                    ctr_d   = '0;
                    state_d = START;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            START: begin
                bus.start = 1'b1;
                ctr_d     = '0;
                state_d   = COLLECT;
            end
            COLLECT: begin
                col_en = 1'b1;
                if (full) begin
                    state_d = CHECK;
                end else if (ctr_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = CHECK;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            CHECK: begin
                done   = 1'b1;
                pass_d = match & ~tmo_q;
                if (tmo_q)
                    tc_d = CNT_W'(sat_inc(32'(tc_q), CNT_W));
                else if (match)
                    pc_d = CNT_W'(sat_inc(32'(pc_q), CNT_W));
                else
                    fc_d = CNT_W'(sat_inc(32'(fc_q), CNT_W));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            len_q   <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            pc_q    <= '0;
            fc_q    <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            len_q   <= len_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            pc_q    <= pc_d;
            fc_q    <= fc_d;
            tc_q    <= tc_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign pass        = pass_q;
    assign timeout     = tmo_q;
    assign pass_cnt    = pc_q;
    assign fail_cnt    = fc_q;
    assign tmo_cnt     = tc_q;
    assign bus.msg_len = len_q;

`ifdef XVD_MISMATCH_DEBUG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obs_q <= '0;
            mm_q  <= '0;
        end else if (state_q == CHECK) begin
            obs_q <= digest;
            mm_q  <= tmo_q ? IW'(DIGEST_BYTES) : mm_c;
        end
    end

    assign obs_digest = obs_q;
    assign mm_idx     = mm_q;
`endif
endmodule

// File: doc/xoodyak_vector_driver.md
Name: xoodyak_vector_driver

Overview:
Synthesizable, parametrised successor to the hand-coded XOODYAK vector loop. It accepts one test vector per cfg handshake: message length plus expected digest. It streams message bytes into XOODYAK via load/msg, pulses start after a programmable gap, then collects DIGEST_BYTES hash bytes on valid and compares them. It sits between a byte source (ROM/bench/UART) and XOODYAK, and keeps pass/fail/timeout counters for unattended regression or FPGA self-test.

Parameters:
DIGEST_BYTES, 32, number of hash bytes collected per vector
LEN_W, 12, width of cfg_len / msg_len
GAP_CYCLES, 5, idle cycles between last load cycle and start pulse (>=1)
TIMEOUT_CYCLES, 4096, max cycles in COLLECT before timeout
CNT_W, 16, width of pass/fail/timeout counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  vector config offered
cfg_ready  out  1  driver idle, config accepted when cfg_valid&cfg_ready
cfg_len  in  LEN_W  XOODYAK msg_len value for this vector
cfg_exp  in  8*DIGEST_BYTES  expected digest, first hash byte in MSBs
src_valid  in  1  message byte available
src_ready  out  1  byte consumed when src_valid&src_ready
src_data  in  8  message byte
load  out  1  XOODYAK load strobe
msg  out  8  XOODYAK message byte
msg_len  out  LEN_W  registered cfg_len, held until next accept
start  out  1  one-cycle XOODYAK start pulse
hash  in  8  XOODYAK hash byte
hash_valid  in  1  XOODYAK valid
busy  out  1  not in IDLE
done  out  1  one-cycle pulse at vector end
pass  out  1  result of last vector, held until next accept
timeout  out  1  last vector timed out, held until next accept
pass_cnt, fail_cnt, tmo_cnt  out  CNT_W  saturating counters

Behaviour:
- Reset: IDLE; outputs/counters 0, except cfg_ready=1; digest register cleared.
- FSM IDLE->LOAD->GAP->START->COLLECT->CHECK->IDLE.
- IDLE: cfg_ready=1. On accept, latch cfg_len/cfg_exp, zero byte counter and digest, go to LOAD.
- LOAD: required byte count = cfg_len+1, per XOODYAK load protocol. src_ready=1. load=src_valid and msg=src_data, both combinational from the registered state.
  - src_valid low: load=0 that cycle (stall), byte not counted.
  - Last byte accepted: go to GAP.
- GAP: load=0; counter runs GAP_CYCLES cycles, then START.
- START: start=1 for exactly one cycle; -> COLLECT; timeout counter cleared.
- COLLECT: each hash_valid cycle shifts digest <= {digest[8*DIGEST_BYTES-9:0], hash}, bytes counted.
  - DIGEST_BYTES bytes seen -> CHECK.
  - Timer reaches TIMEOUT_CYCLES-1 with no completion -> CHECK with timeout flag set.
  - hash_valid outside COLLECT is ignored.
- CHECK (1 cycle): done=1.
  - pass=(digest==exp) & ~timeout.
  - Increment exactly one of pass_cnt/fail_cnt/tmo_cnt. Timeout counts only in tmo_cnt.
  - Counters saturate at all-ones.
  - -> IDLE.
- cfg_valid while busy: ignored, cfg_ready=0.
- Reset mid-operation: immediate return to reset state. load/start drop asynchronously. Counters cleared.
- Latency: start issued exactly GAP_CYCLES+1 cycles after last load cycle; done 1 cycle after last hash byte.

Optional Feature:
Macro XVD_MISMATCH_DEBUG_EN.
- Defined: extra outputs obs_digest (8*DIGEST_BYTES, last collected digest, held) and mm_idx (clog2(DIGEST_BYTES)+1 bits, index of first differing byte from MSB, 0..DIGEST_BYTES-1; value DIGEST_BYTES when equal or timed out). Both are registered in CHECK.
- Undefined: ports absent; comparator is a single equality only.

Decomposition:
- Package xoodyak_tb_pkg:
  - FSM state enum (IDLE, LOAD, GAP, START, COLLECT, CHECK)
  - XOODYAK_BYTE_W=8
  - default DIGEST_BYTES=32
  - saturating-increment function
- One sub-module, xvd_digest_collector:
  - shift register, byte counter, comparator, optional mismatch index
  - inputs clear/hash/hash_valid/en; outputs full/match.

Test Plan:
- cfg_len=0, src byte 0xFF, XOODYAK model -> load high 1 cycle with msg=0xFF, start 6 cycles later, 32 hash bytes -> with cfg_exp=EA152F2B...DC8F8BD1: done, pass=1, pass_cnt=1.
- Same vector with cfg_exp LSB flipped -> pass=0, fail_cnt=1. With macro: mm_idx=31.
- cfg_len=11, src_valid toggling 1-0-1 -> exactly 12 load cycles, no load during stalls, msg order preserved, vector 11 digest C23BF64C...E30BB065 passes.
- Hash model sends only 31 bytes, TIMEOUT_CYCLES=64 -> done 64 cycles after entering COLLECT, timeout=1, tmo_cnt=1, fail_cnt=0.
- Reset asserted in LOAD after 3 bytes -> load=0 same cycle, busy=0, cfg_ready=1, counters 0. A new cfg then completes normally.
- 12 back-to-back vectors (cfg_valid held high) -> cfg_ready low while busy, pass_cnt=12. A stray hash_valid in IDLE leaves the digest unchanged.
